// File: rtl/qdec_cabac_package.sv
// Shared CABAC decoder types and context indices for the QP sub-FSM.
package qdec_cabac_package;

  typedef enum logic [2:0] {
    StIdle,
    StDqpPrefix,
    StDqpEgPrefix,
    StDqpEgBits,
    StDqpSign,
    StCqpFlag,
    StCqpIdx,
    StEnding
  } t_state_qp;

  localparam int unsigned CTXIDX_CU_QP_DELTA_ABS          [0:1] = '{32, 33};
  localparam int unsigned CTXIDX_CU_CHROMA_QP_OFFSET_FLAG [0:0] = '{40};
  localparam int unsigned CTXIDX_CU_CHROMA_QP_OFFSET_IDX  [0:0] = '{41};

  function automatic logic is_dec_state(input t_state_qp s);
    return (s != StIdle) && (s != StEnding);
  endfunction

endpackage

// File: rtl/qdec_eg0_acc.sv
// EG0 suffix accumulator: unary k counter, MSB-first suffix bits, overflow detect.
module qdec_eg0_acc #(
  parameter int unsigned KMax = 15,
  parameter int unsigned SufW = KMax + 1,
  parameter int unsigned KW   = $clog2(KMax + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_i,
  input  logic            pfx_vld_i,
  input  logic            bits_vld_i,
  input  logic            bin_i,
  output logic [KW-1:0]   k_o,
  output logic [SufW-1:0] suffix_o,
  output logic            ovf_o,
  output logic            last_bit_o
);

  logic [KW-1:0]   k_q, k_d;
  logic [SufW-1:0] suf_q, suf_d;

  // In the bits phase k doubles as the count of bits still to read.
  always_comb begin
    k_d   = k_q;
    suf_d = suf_q;
    if (clr_i) begin
      k_d   = '0;
      suf_d = '0;
    end else if (pfx_vld_i && bin_i) begin
      suf_d = suf_q + (SufW'(1) << k_q);
      k_d   = k_q + KW'(1);
    end else if (bits_vld_i) begin
      if (bin_i) suf_d = suf_q + (SufW'(1) << (k_q - KW'(1)));
      k_d = k_q - KW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q   <= '0;
      suf_q <= '0;
    end else begin
      k_q   <= k_d;
      suf_q <= suf_d;
    end
  end

  assign k_o        = k_q;
  assign suffix_o   = suf_q;
  assign ovf_o      = pfx_vld_i && bin_i && (k_q == KW'(KMax - 1));
  assign last_bit_o = (k_q == KW'(1));

endmodule

// File: rtl/qdec_qp_fsm.sv
// CABAC sub-FSM decoding cu_qp_delta_abs/sign and the chroma QP offset flag/index.
module qdec_qp_fsm
  import qdec_cabac_package::*;
#(
  parameter int unsigned CTX_ADDR_W     = 10,
  parameter int unsigned DQP_PREFIX_MAX = 5,
  parameter int unsigned EG_K_MAX       = 15,
  parameter int unsigned DQP_W          = 16,
  parameter int unsigned CQP_IDX_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  qp_start,
  input  logic                  cu_qp_delta_enabled_flag,
  input  logic                  cu_chroma_qp_offset_enabled_flag,
  input  logic [CQP_IDX_W-1:0]  chroma_qp_offset_list_len_minus1,
  output logic [CTX_ADDR_W-1:0] ctx_qp_addr,
  output logic                  EPMode_qp,
  output logic                  dec_run_qp,
  input  logic                  dec_rdy,
  input  logic                  ruiBin,
  input  logic                  ruiBin_vld,
  output logic [DQP_W-1:0]      cu_qp_delta_val,
  output logic                  cu_chroma_qp_offset_flag,
  output logic [CQP_IDX_W-1:0]  cu_chroma_qp_offset_idx,
  output logic                  qp_err,
  output logic                  qp_done_intr
);

  localparam int unsigned PW   = $clog2(DQP_PREFIX_MAX + 1);
  localparam int unsigned SufW = EG_K_MAX + 1;
  localparam int unsigned KW   = $clog2(EG_K_MAX + 1);

  t_state_qp state_q, state_d;
  logic                  pend_q, pend_d;
  logic                  run_q, run_d;
  logic                  ep_q, ep_d;
  logic [CTX_ADDR_W-1:0] addr_q, addr_d;
  logic [PW-1:0]         prefix_q, prefix_d;
  logic [CQP_IDX_W-1:0]  idx_q, idx_d;
  logic [CQP_IDX_W-1:0]  len_q, len_d;
  logic                  en_cqp_q, en_cqp_d;
  logic [DQP_W-1:0]      dqp_q, dqp_d;
  logic                  flag_q, flag_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;

  logic                  bin_take;
  logic                  eg_clr, eg_pfx_vld, eg_bits_vld, eg_ovf, eg_last;
  logic [KW-1:0]         eg_k;
  logic [SufW-1:0]       eg_suffix;
  logic [PW-1:0]         prefix_inc;
  logic [CQP_IDX_W-1:0]  idx_inc;
  logic [DQP_W-1:0]      dqp_abs;
  t_state_qp             chroma_next;

  assign bin_take    = pend_q && ruiBin_vld;
  assign eg_pfx_vld  = bin_take && (state_q == StDqpEgPrefix);
  assign eg_bits_vld = bin_take && (state_q == StDqpEgBits);
  assign eg_clr      = (state_q == StIdle) && qp_start;
  assign prefix_inc  = prefix_q + PW'(1);
  assign idx_inc     = idx_q + CQP_IDX_W'(1);
  assign dqp_abs     = DQP_W'(prefix_q) + DQP_W'(eg_suffix);
  assign chroma_next = en_cqp_q ? StCqpFlag : StEnding;

  qdec_eg0_acc #(
    .KMax (EG_K_MAX),
    .SufW (SufW),
    .KW   (KW)
  ) u_eg0_acc (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (eg_clr),
    .pfx_vld_i  (eg_pfx_vld),
    .bits_vld_i (eg_bits_vld),
    .bin_i      (ruiBin),
    .k_o        (eg_k),
    .suffix_o   (eg_suffix),
    .ovf_o      (eg_ovf),
    .last_bit_o (eg_last)
  );

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    run_d    = 1'b0;
    ep_d     = ep_q;
    addr_d   = addr_q;
    prefix_d = prefix_q;
    idx_d    = idx_q;
    len_d    = len_q;
    en_cqp_d = en_cqp_q;
    dqp_d    = dqp_q;
    flag_d   = flag_q;
    err_d    = err_q;
    done_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (qp_start) begin
          dqp_d    = '0;
          flag_d   = 1'b0;
          idx_d    = '0;
          err_d    = 1'b0;
          prefix_d = '0;
          en_cqp_d = cu_chroma_qp_offset_enabled_flag;
          len_d    = chroma_qp_offset_list_len_minus1;
          if (cu_qp_delta_enabled_flag)              state_d = StDqpPrefix;
          else if (cu_chroma_qp_offset_enabled_flag) state_d = StCqpFlag;
          else                                       state_d = StEnding;
        end
      end
      StDqpPrefix: begin
        if (bin_take) begin
          if (ruiBin) begin
            prefix_d = prefix_inc;
            if (prefix_inc == PW'(DQP_PREFIX_MAX)) state_d = StDqpEgPrefix;
          end else begin
            state_d = (prefix_q == '0) ? chroma_next : StDqpSign;
          end
        end
      end
      StDqpEgPrefix: begin
        if (bin_take) begin
          if (ruiBin) begin
            if (eg_ovf) begin
              err_d   = 1'b1;
              state_d = StEnding;
            end
          end else begin
            state_d = (eg_k == '0) ? StDqpSign : StDqpEgBits;
          end
        end
      end
      StDqpEgBits: begin
        if (bin_take && eg_last) state_d = StDqpSign;
      end
      StDqpSign: begin
        if (bin_take) begin
          dqp_d   = ruiBin ? (DQP_W'(0) - dqp_abs) : dqp_abs;
          state_d = chroma_next;
        end
      end
      StCqpFlag: begin
        if (bin_take) begin
          flag_d  = ruiBin;
          idx_d   = '0;
          state_d = (ruiBin && (len_q != '0)) ? StCqpIdx : StEnding;
        end
      end
      StCqpIdx: begin
        if (bin_take) begin
          if (ruiBin) begin
            idx_d = idx_inc;
            if (idx_inc == len_q) state_d = StEnding;
          end else begin
            state_d = StEnding;
          end
        end
      end
      StEnding: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (bin_take) pend_d = 1'b0;

    // Issue only when idle on the bin bus; a request can never overlap a consume.
    if (is_dec_state(state_q) && !pend_q && dec_rdy) begin
      run_d  = 1'b1;
      pend_d = 1'b1;
      case (state_q)
        StDqpPrefix: begin
          ep_d   = 1'b0;
          addr_d = (prefix_q == '0) ? CTX_ADDR_W'(CTXIDX_CU_QP_DELTA_ABS[0])
                                    : CTX_ADDR_W'(CTXIDX_CU_QP_DELTA_ABS[1]);
        end
        StCqpFlag: begin
          ep_d   = 1'b0;
          addr_d = CTX_ADDR_W'(CTXIDX_CU_CHROMA_QP_OFFSET_FLAG[0]);
        end
        StCqpIdx: begin
          ep_d   = 1'b0;
          addr_d = CTX_ADDR_W'(CTXIDX_CU_CHROMA_QP_OFFSET_IDX[0]);
        end
        default: begin
          ep_d   = 1'b1;
          addr_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      pend_q   <= 1'b0;
      run_q    <= 1'b0;
      ep_q     <= 1'b0;
      addr_q   <= '0;
      prefix_q <= '0;
      idx_q    <= '0;
      len_q    <= '0;
      en_cqp_q <= 1'b0;
      dqp_q    <= '0;
      flag_q   <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      run_q    <= run_d;
      ep_q     <= ep_d;
      addr_q   <= addr_d;
      prefix_q <= prefix_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      en_cqp_q <= en_cqp_d;
      dqp_q    <= dqp_d;
      flag_q   <= flag_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  assign ctx_qp_addr              = addr_q;
  assign EPMode_qp                = ep_q;
  assign dec_run_qp               = run_q;
  assign cu_qp_delta_val          = dqp_q;
  assign cu_chroma_qp_offset_flag = flag_q;
  assign cu_chroma_qp_offset_idx  = idx_q;
  assign qp_err                   = err_q;
  assign qp_done_intr             = done_q;

endmodule

// File: tb/tb_qdec_qp_fsm.sv
// Directed bench for qdec_qp_fsm: a bin-decoder responder driven step by step.
module tb_qdec_qp_fsm;
  import qdec_cabac_package::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        qp_start;
  logic        dqp_en;
  logic        cqp_en;
  logic [2:0]  len_m1;
  logic [9:0]  ctx_qp_addr;
  logic        EPMode_qp;
  logic        dec_run_qp;
  logic        dec_rdy;
  logic        ruiBin;
  logic        ruiBin_vld;
  logic [15:0] dqp_val;
  logic        cqp_flag;
  logic [2:0]  cqp_idx;
  logic        qp_err;
  logic        qp_done_intr;

  int checks = 0;
  int failures = 0;
  int req_cnt = 0;
  int done_cnt = 0;
  int req_base;
  int done_base;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dec_run_qp) req_cnt++;
    if (qp_done_intr) done_cnt++;
  end

  qdec_qp_fsm dut (
    .clk                              (clk),
    .rst                              (rst),
    .qp_start                         (qp_start),
    .cu_qp_delta_enabled_flag         (dqp_en),
    .cu_chroma_qp_offset_enabled_flag (cqp_en),
    .chroma_qp_offset_list_len_minus1 (len_m1),
    .ctx_qp_addr                      (ctx_qp_addr),
    .EPMode_qp                        (EPMode_qp),
    .dec_run_qp                       (dec_run_qp),
    .dec_rdy                          (dec_rdy),
    .ruiBin                           (ruiBin),
    .ruiBin_vld                       (ruiBin_vld),
    .cu_qp_delta_val                  (dqp_val),
    .cu_chroma_qp_offset_flag         (cqp_flag),
    .cu_chroma_qp_offset_idx          (cqp_idx),
    .qp_err                           (qp_err),
    .qp_done_intr                     (qp_done_intr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for a request, check its address/mode, answer one cycle later.
  task automatic serve(input string tag, input logic b, input logic exp_ep, input int exp_addr);
    int n = 0;
    while (!dec_run_qp && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req"}, 32'(dec_run_qp), 32'd1);
    if (!dec_run_qp) return;
    chk({tag, "_ep"}, 32'(EPMode_qp), 32'(exp_ep));
    if (exp_addr >= 0) chk({tag, "_addr"}, 32'(ctx_qp_addr), 32'(exp_addr));
    @(negedge clk);
    ruiBin_vld = 1'b1;
    ruiBin     = b;
    @(negedge clk);
    ruiBin_vld = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!qp_done_intr && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, 32'(qp_done_intr), 32'd1);
  endtask

  task automatic start(input logic d, input logic c, input logic [2:0] l);
    dqp_en   = d;
    cqp_en   = c;
    len_m1   = l;
    qp_start = 1'b1;
    @(negedge clk);
    qp_start = 1'b0;
  endtask

  task automatic chk_outs(input string tag, input logic [15:0] v, input logic f,
                          input logic [2:0] i, input logic e);
    chk({tag, "_val"}, 32'(dqp_val), 32'(v));
    chk({tag, "_flag"}, 32'(cqp_flag), 32'(f));
    chk({tag, "_idx"}, 32'(cqp_idx), 32'(i));
    chk({tag, "_err"}, 32'(qp_err), 32'(e));
  endtask

  initial begin
    rst = 1'b1; qp_start = 1'b0; dqp_en = 1'b0; cqp_en = 1'b0; len_m1 = 3'd0;
    dec_rdy = 1'b1; ruiBin = 1'b0; ruiBin_vld = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_run", 32'(dec_run_qp), 32'd0);
    chk("rst_done", 32'(qp_done_intr), 32'd0);
    chk("rst_ep", 32'(EPMode_qp), 32'd0);
    chk("rst_addr", 32'(ctx_qp_addr), 32'd0);
    chk_outs("rst", 16'h0, 1'b0, 3'd0, 1'b0);

    // Both enables off: done exactly two cycles after the start cycle, no requests.
    req_base = req_cnt;
    start(1'b0, 1'b0, 3'd0);
    chk("none_done_c1", 32'(qp_done_intr), 32'd0);
    @(negedge clk);
    chk("none_done_c2", 32'(qp_done_intr), 32'd1);
    @(negedge clk);
    chk("none_done_c3", 32'(qp_done_intr), 32'd0);
    chk("none_reqs", 32'(req_cnt - req_base), 32'd0);
    chk_outs("none", 16'h0, 1'b0, 3'd0, 1'b0);

    // Delta only: prefix 1,1,0 then sign 1 -> -2.
    start(1'b1, 1'b0, 3'd0);
    serve("d_p0", 1'b1, 1'b0, 32);
    serve("d_p1", 1'b1, 1'b0, 33);
    serve("d_p2", 1'b0, 1'b0, 33);
    serve("d_sg", 1'b1, 1'b1, -1);
    wait_done("d");
    chk_outs("d", 16'hFFFE, 1'b0, 3'd0, 1'b0);

    // Full prefix, EG0 1,0, bit 1, sign 0 -> +7; then chroma flag 0.
    req_base = req_cnt;
    start(1'b1, 1'b1, 3'd3);
    for (int i = 0; i < 5; i++) serve("eg_p", 1'b1, 1'b0, (i == 0) ? 32 : 33);
    serve("eg_k0", 1'b1, 1'b1, -1);
    serve("eg_k1", 1'b0, 1'b1, -1);
    serve("eg_b0", 1'b1, 1'b1, -1);
    serve("eg_sg", 1'b0, 1'b1, -1);
    serve("eg_cf", 1'b0, 1'b0, 40);
    wait_done("eg");
    chk("eg_reqs", 32'(req_cnt - req_base), 32'd10);
    chk_outs("eg", 16'd7, 1'b0, 3'd0, 1'b0);

    // Chroma only, len 3: flag 1, idx 1,1,0 -> idx 2.
    start(1'b0, 1'b1, 3'd3);
    serve("c3_f", 1'b1, 1'b0, 40);
    serve("c3_i0", 1'b1, 1'b0, 41);
    serve("c3_i1", 1'b1, 1'b0, 41);
    serve("c3_i2", 1'b0, 1'b0, 41);
    wait_done("c3");
    chk_outs("c3", 16'h0, 1'b1, 3'd2, 1'b0);

    // Chroma only, len 2: idx saturates at cMax with no third idx request.
    req_base = req_cnt;
    start(1'b0, 1'b1, 3'd2);
    serve("c2_f", 1'b1, 1'b0, 40);
    serve("c2_i0", 1'b1, 1'b0, 41);
    serve("c2_i1", 1'b1, 1'b0, 41);
    wait_done("c2");
    repeat (4) @(negedge clk);
    chk("c2_reqs", 32'(req_cnt - req_base), 32'd3);
    chk_outs("c2", 16'h0, 1'b1, 3'd2, 1'b0);

    // EG0 overflow: 15 unary ones -> qp_err, no sign, no chroma.
    req_base = req_cnt;
    start(1'b1, 1'b1, 3'd3);
    for (int i = 0; i < 5; i++) serve("ov_p", 1'b1, 1'b0, (i == 0) ? 32 : 33);
    for (int i = 0; i < 15; i++) serve("ov_k", 1'b1, 1'b1, -1);
    wait_done("ov");
    repeat (4) @(negedge clk);
    chk("ov_reqs", 32'(req_cnt - req_base), 32'd20);
    chk_outs("ov", 16'h0, 1'b0, 3'd0, 1'b1);

    // Stall, ignored restart, then reset with a request outstanding in CQP_IDX.
    dec_rdy  = 1'b0;
    req_base = req_cnt;
    done_base = done_cnt;
    start(1'b1, 1'b1, 3'd3);
    chk("st_err_clr", 32'(qp_err), 32'd0);
    repeat (4) @(negedge clk);
    start(1'b0, 1'b0, 3'd0);
    repeat (5) @(negedge clk);
    chk("st_no_req", 32'(req_cnt - req_base), 32'd0);
    chk("st_no_done", 32'(done_cnt - done_base), 32'd0);
    dec_rdy = 1'b1;
    serve("st_p0", 1'b0, 1'b0, 32);
    serve("st_f", 1'b1, 1'b0, 40);
    serve("st_i0", 1'b1, 1'b0, 41);
    begin
      int n = 0;
      while (!dec_run_qp && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    chk("st_i1_req", 32'(dec_run_qp), 32'd1);
    chk("st_i1_addr", 32'(ctx_qp_addr), 32'd41);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ruiBin_vld = 1'b1;
    ruiBin     = 1'b1;
    @(negedge clk);
    ruiBin_vld = 1'b0;
    repeat (5) @(negedge clk);
    chk("sr_run", 32'(dec_run_qp), 32'd0);
    chk("sr_addr", 32'(ctx_qp_addr), 32'd0);
    chk("sr_ep", 32'(EPMode_qp), 32'd0);
    chk("sr_no_done", 32'(done_cnt - done_base), 32'd0);
    chk_outs("sr", 16'h0, 1'b0, 3'd0, 1'b0);

    // Back in IDLE: a plain start completes on schedule.
    start(1'b0, 1'b0, 3'd0);
    @(negedge clk);
    chk("post_done", 32'(qp_done_intr), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qdec_qp_fsm.md
# qdec_qp_fsm

CABAC sub-FSM that decodes all QP-related CU syntax elements: `cu_qp_delta_abs` (TU prefix plus EG0 suffix), `cu_qp_delta_sign_flag`, `cu_chroma_qp_offset_flag` and `cu_chroma_qp_offset_idx`. It is the generalised successor of the chroma-QP-offset sub-FSM.
- Parametrised prefix length, EG0 suffix limit, index list length and output widths.
- Uses a request/response bin handshake in place of fixed phase counting.
- Produces a decoded `CuQpDeltaVal` and chroma-offset index, not only a done pulse.

It sits under the CU FSM and shares the bin decoder with the other sub-FSMs.

## Interface
Parameters:
- `CTX_ADDR_W`, 10: context-memory address width.
- `DQP_PREFIX_MAX`, 5: TU cMax of the `cu_qp_delta_abs` prefix.
- `EG_K_MAX`, 15: maximum EG0 unary-prefix length; exceeding it raises an error.
- `DQP_W`, 16: width of the signed `cu_qp_delta_val`.
- `CQP_IDX_W`, 3: width of the index and list-length fields.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `qp_start` in 1: one-cycle start pulse; honoured only in IDLE.
- `cu_qp_delta_enabled_flag` in 1: `cu_qp_delta_abs` is coded for this CU.
- `cu_chroma_qp_offset_enabled_flag` in 1: the chroma offset flag is coded for this CU.
- `chroma_qp_offset_list_len_minus1` in `CQP_IDX_W`: 0..5.
- `ctx_qp_addr` out `CTX_ADDR_W`: context address of the current bin.
- `EPMode_qp` out 1: current bin is bypass.
- `dec_run_qp` out 1: one-cycle bin request.
- `dec_rdy` in 1: decoder can accept a request.
- `ruiBin` in 1: decoded bin value.
- `ruiBin_vld` in 1: bin valid, exactly once per request, at least 1 cycle after it.
- `cu_qp_delta_val` out `DQP_W`: signed result.
- `cu_chroma_qp_offset_flag` out 1: decoded flag.
- `cu_chroma_qp_offset_idx` out `CQP_IDX_W`: decoded index.
- `qp_err` out 1: sticky EG0 overflow flag; cleared on `qp_start`.
- `qp_done_intr` out 1: one-cycle done pulse.

## Operation
- States: IDLE, DQP_PREFIX, DQP_EG_PREFIX, DQP_EG_BITS, DQP_SIGN, CQP_FLAG, CQP_IDX, ENDING.
- IDLE + `qp_start`: the next state depends on the enables.
  - `cu_qp_delta_enabled_flag` set → DQP_PREFIX.
  - Otherwise, `cu_chroma_qp_offset_enabled_flag` set → CQP_FLAG.
  - Otherwise → ENDING.
  - On start, `cu_qp_delta_val`, `cu_chroma_qp_offset_flag`, `cu_chroma_qp_offset_idx` and `qp_err` are cleared.
- DQP_PREFIX: context-coded bins.
  - Bin 0 uses `CTXIDX_CU_QP_DELTA_ABS[0]`; later bins use `[1]`.
  - A 0 bin ends the prefix; value = count of 1s.
  - Reaching `DQP_PREFIX_MAX` ones ends it with no terminating bin.
  - Prefix value 0 → skip sign, go to the chroma check.
  - Prefix 1..MAX-1 → DQP_SIGN.
  - Prefix == MAX → DQP_EG_PREFIX.
- DQP_EG_PREFIX: bypass bins.
  - Each 1 adds `1<<k` to the suffix, then k++.
  - A 0 → DQP_EG_BITS, which reads k bypass bins MSB-first and adds them to the suffix.
  - k == 0 → go straight to DQP_SIGN.
  - k reaching `EG_K_MAX` without a 0 → set `qp_err` and go to ENDING.
- abs = prefix + suffix. DQP_SIGN reads one bypass bin; 1 means negative. `cu_qp_delta_val` = ±abs, sign-extended to `DQP_W`.
- Chroma check: if `cu_chroma_qp_offset_enabled_flag` → CQP_FLAG, else ENDING.
- CQP_FLAG: one context bin at `CTXIDX_CU_CHROMA_QP_OFFSET_FLAG`.
  - Flag 1 and `list_len_minus1` > 0 → CQP_IDX.
  - Otherwise → ENDING, with idx = 0.
- CQP_IDX: TR coding, cMax = `list_len_minus1`, all bins at `CTXIDX_CU_CHROMA_QP_OFFSET_IDX`.
  - Each 1 increments idx.
  - Stop on a 0, or on idx reaching cMax with no extra bin.
- ENDING: pulse `qp_done_intr` for one cycle, then return to IDLE. Outputs hold until the next `qp_start`.

## Timing
- Reset values:
  - State IDLE.
  - `dec_run_qp`, `qp_done_intr`, `EPMode_qp`, `qp_err`, `cu_chroma_qp_offset_flag` = 0.
  - `ctx_qp_addr`, `cu_qp_delta_val`, `cu_chroma_qp_offset_idx` = 0.
- At most one request outstanding.
  - `dec_run_qp` is registered and asserted for one cycle when: state is a decoding state, no request is outstanding, and `dec_rdy` = 1.
  - `ctx_qp_addr` and `EPMode_qp` are valid in the same cycle and held until `ruiBin_vld`.
- The bin is consumed in the `ruiBin_vld` cycle.
  - The state or counter update is visible the next cycle.
  - The next request is issued no earlier than 1 cycle after `ruiBin_vld`.
- `dec_rdy` low stalls issue indefinitely; no timeout.
- `ruiBin_vld` with no request outstanding is ignored.
- `qp_start` outside IDLE is ignored.
- `rst` mid-operation: return to IDLE on the next edge; any outstanding bin is dropped and no `qp_done_intr` is generated.
- With both enables 0: `qp_done_intr` is high 2 cycles after the `qp_start` cycle.
- `qp_done_intr` rises the cycle after the final `ruiBin_vld` + 1 (state ENDING registered).

## Structure
- `qdec_cabac_package` holds:
  - the `t_state_qp` enum;
  - `CTXIDX_CU_QP_DELTA_ABS[0:1]`, `CTXIDX_CU_CHROMA_QP_OFFSET_FLAG[0]` and `CTXIDX_CU_CHROMA_QP_OFFSET_IDX[0]`.
- One natural sub-module: `qdec_eg0_acc`, an EG0 suffix accumulator (k counter, suffix register, overflow detect). It is reusable for `coeff_abs_level_remaining`.

## Test plan
- Both enables 0, `qp_start` → no `dec_run_qp`; `qp_done_intr` 2 cycles later; all outputs 0.
- Delta only, bins 1,1,0 then sign 1 → addresses [0],[1],[1] then EP; `cu_qp_delta_val` = -2.
- Prefix 1,1,1,1,1, EG bins 1,0, suffix bit 1, sign 0 → 5 ctx bins and 4 EP bins; value = +7.
- Chroma flag 1, `list_len_minus1` = 3, idx bins 1,1,0 → idx 2. With `list_len_minus1` = 2 and bins 1,1 → idx 2, and no third request.
- EG prefix of 15 ones → `qp_err` = 1; ENDING without sign; done pulse.
- `dec_rdy` held low 10 cycles, `qp_start` re-pulsed mid-decode, then `rst` mid-CQP_IDX → no requests during stall; restart ignored; IDLE after reset with all outputs 0 and no done pulse.
